// File: rtl/pool_frame_ctrl.sv
// Frame sequencer for one maxpooling stage: raster sweep, source pull with stall,
// pipeline drain, pooled-output counting. Define POOL_FRAME_CTRL_CONT_EN for back-to-back frames.
module pool_frame_ctrl #(
   parameter int WIDTH        = 8,
   parameter int HEIGHT       = 4,
   parameter int W_WIDTH      = 10,
   parameter int W_HEIGHT     = 6,
   parameter int LEVEL        = 0,
   parameter int DRAIN_CYCLES = 16,
   localparam int V_BITW      = $clog2(W_HEIGHT),
   localparam int H_BITW      = $clog2(W_WIDTH)
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   input  logic              src_valid,
   output logic              src_ready,
   output logic              stg_enable,
   output logic [V_BITW-1:0] stg_vcnt,
   output logic [H_BITW-1:0] stg_hcnt,
   input  logic              pool_out_enable,
   input  logic [V_BITW-1:0] pool_vcnt,
   input  logic [H_BITW-1:0] pool_hcnt,
   output logic [15:0]       pool_count,
   output logic              count_err,
   output logic [15:0]       stall_count
);

   localparam int                DR_BITW    = $clog2(DRAIN_CYCLES + 1);
   localparam logic [V_BITW-1:0] HEIGHT_V   = V_BITW'(HEIGHT);
   localparam logic [H_BITW-1:0] WIDTH_H    = H_BITW'(WIDTH);
   localparam logic [V_BITW-1:0] LAST_V     = V_BITW'(W_HEIGHT - 1);
   localparam logic [H_BITW-1:0] LAST_H     = H_BITW'(W_WIDTH - 1);
   localparam logic [DR_BITW-1:0] DRAIN_LAST = DR_BITW'(DRAIN_CYCLES - 1);
   localparam logic [15:0]       EXPECTED   = 16'((WIDTH >> (LEVEL + 1)) * (HEIGHT >> (LEVEL + 1)));
   localparam logic [15:0]       SAT        = 16'hFFFF;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

   state_t              state_r, state_s;
   logic [V_BITW-1:0]   vcnt_r, vcnt_s, adv_v_s;
   logic [H_BITW-1:0]   hcnt_r, hcnt_s, adv_h_s;
   logic [DR_BITW-1:0]  drain_r, drain_s;
   logic [15:0]         pool_r, pool_s, stall_r, stall_cnt_s;
   logic                err_r, err_s, busy_r, done_r;
   logic                active_s, stall_s, pool_hit_s, src_ready_s, stg_enable_s;
`ifdef POOL_FRAME_CTRL_CONT_EN
   logic                cont_r, cont_s;
`endif

   // Raster position, stall detection and stage handshake outputs
   always_comb begin
      active_s     = (vcnt_r < HEIGHT_V) && (hcnt_r < WIDTH_H);
      stall_s      = (state_r == RUN) && active_s && !src_valid;
      pool_hit_s   = pool_out_enable && (pool_vcnt < HEIGHT_V) && (pool_hcnt < WIDTH_H)
                     && (&pool_vcnt[LEVEL:0]) && (&pool_hcnt[LEVEL:0]);
      adv_h_s      = (hcnt_r == LAST_H) ? {H_BITW{1'b0}} : hcnt_r + 1'b1;
      adv_v_s      = (hcnt_r != LAST_H) ? vcnt_r :
                     (vcnt_r == LAST_V) ? {V_BITW{1'b0}} : vcnt_r + 1'b1;
      src_ready_s  = 1'b0;
      stg_enable_s = 1'b0;
      case (state_r)
         RUN: begin
            src_ready_s  = active_s && src_valid;
            stg_enable_s = !active_s || src_valid;
         end
         DRAIN: begin
            stg_enable_s = 1'b1;
         end
         default: begin
            stg_enable_s = 1'b0;
         end
      endcase
   end

   // Next-state, raster and counter update
   always_comb begin
      state_s     = state_r;
      vcnt_s      = vcnt_r;
      hcnt_s      = hcnt_r;
      drain_s     = drain_r;
      pool_s      = pool_r;
      stall_cnt_s = stall_r;
      err_s       = err_r;
`ifdef POOL_FRAME_CTRL_CONT_EN
      cont_s      = cont_r;
`endif
      if (((state_r == RUN) || (state_r == DRAIN)) && pool_hit_s && (pool_r != SAT)) begin
         pool_s = pool_r + 16'd1;
      end else begin
         pool_s = pool_r;
      end
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s     = RUN;
               vcnt_s      = {V_BITW{1'b0}};
               hcnt_s      = {H_BITW{1'b0}};
               pool_s      = 16'd0;
               stall_cnt_s = 16'd0;
               err_s       = 1'b0;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (stall_s) begin
               stall_cnt_s = (stall_r == SAT) ? stall_r : stall_r + 16'd1;
            end else begin
               vcnt_s = adv_v_s;
               hcnt_s = adv_h_s;
               if ((vcnt_r == LAST_V) && (hcnt_r == LAST_H)) begin
                  state_s = DRAIN;
                  drain_s = {DR_BITW{1'b0}};
               end else begin
                  state_s = RUN;
               end
            end
         end
         DRAIN: begin
            vcnt_s = adv_v_s;
            hcnt_s = adv_h_s;
            if (drain_r == DRAIN_LAST) begin
               // Compare against this cycle's updated count so a final hit is included
               state_s = DONE;
               vcnt_s  = {V_BITW{1'b0}};
               hcnt_s  = {H_BITW{1'b0}};
               err_s   = (pool_s != EXPECTED);
`ifdef POOL_FRAME_CTRL_CONT_EN
               cont_s  = start;
`endif
            end else begin
               drain_s = drain_r + 1'b1;
            end
         end
         DONE: begin
`ifdef POOL_FRAME_CTRL_CONT_EN
            if (cont_r) begin
               state_s     = RUN;
               pool_s      = 16'd0;
               stall_cnt_s = 16'd0;
               err_s       = 1'b0;
               cont_s      = 1'b0;
            end else begin
               state_s = IDLE;
            end
`else
            state_s = IDLE;
`endif
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and counter registers
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         vcnt_r  <= {V_BITW{1'b0}};
         hcnt_r  <= {H_BITW{1'b0}};
         drain_r <= {DR_BITW{1'b0}};
         pool_r  <= 16'd0;
         stall_r <= 16'd0;
         err_r   <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
`ifdef POOL_FRAME_CTRL_CONT_EN
         cont_r  <= 1'b0;
`endif
      end else begin
         state_r <= state_s;
         vcnt_r  <= vcnt_s;
         hcnt_r  <= hcnt_s;
         drain_r <= drain_s;
         pool_r  <= pool_s;
         stall_r <= stall_cnt_s;
         err_r   <= err_s;
         busy_r  <= (state_s == RUN) || (state_s == DRAIN);
         done_r  <= (state_s == DONE);
`ifdef POOL_FRAME_CTRL_CONT_EN
         cont_r  <= cont_s;
`endif
      end
   end

   assign busy        = busy_r;
   assign done        = done_r;
   assign src_ready   = src_ready_s;
   assign stg_enable  = stg_enable_s;
   assign stg_vcnt    = vcnt_r;
   assign stg_hcnt    = hcnt_r;
   assign pool_count  = pool_r;
   assign count_err   = err_r;
   assign stall_count = stall_r;

endmodule

// File: tb/tb_pool_frame_ctrl.sv
// Scoreboard bench for pool_frame_ctrl: expected consumed raster positions are queued
// per frame and popped on each src_ready; frame results are checked at done.
module tb_pool_frame_ctrl;

   logic        clock = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        busy, done;
   logic        src_valid = 1'b1;
   logic        src_ready, stg_enable;
   logic [2:0]  stg_vcnt;
   logic [3:0]  stg_hcnt;
   logic        pool_out_enable;
   logic [2:0]  pool_vcnt;
   logic [3:0]  pool_hcnt;
   logic [15:0] pool_count, stall_count;
   logic        count_err;

   pool_frame_ctrl dut (
      .clock(clock), .rst(rst), .start(start), .busy(busy), .done(done),
      .src_valid(src_valid), .src_ready(src_ready), .stg_enable(stg_enable),
      .stg_vcnt(stg_vcnt), .stg_hcnt(stg_hcnt), .pool_out_enable(pool_out_enable),
      .pool_vcnt(pool_vcnt), .pool_hcnt(pool_hcnt), .pool_count(pool_count),
      .count_err(count_err), .stall_count(stall_count)
   );

   always #5 clock = ~clock;

   // Stage model: every consumed pixel re-emerges four cycles later, optionally dropping (3,7)
   bit         drop_en = 1'b0;
   logic [3:0] pe = 4'd0;
   logic [2:0] pv [4];
   logic [3:0] ph [4];
   always @(posedge clock) begin
      pe    <= {pe[2:0], src_ready && !(drop_en && stg_vcnt == 3'd3 && stg_hcnt == 4'd7)};
      pv[0] <= stg_vcnt;
      ph[0] <= stg_hcnt;
      for (int k = 1; k < 4; k++) begin
         pv[k] <= pv[k-1];
         ph[k] <= ph[k-1];
      end
   end
   assign pool_out_enable = pe[3];
   assign pool_vcnt       = pv[3];
   assign pool_hcnt       = ph[3];

   typedef struct {
      logic [2:0] v;
      logic [3:0] h;
   } pos_t;
   pos_t exp_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_seen = 0;
   int done_cyc = 0;
   int stall_rem = 0;
   bit poke = 1'b0;
   logic [2:0] stall_v = 3'd0;
   logic [3:0] stall_h = 4'd0;

   task automatic push_frame();
      pos_t p;
      for (int v = 0; v < 4; v++) begin
         for (int h = 0; h < 8; h++) begin
            p.v = 3'(v);
            p.h = 4'(h);
            exp_q.push_back(p);
         end
      end
   endtask

   // One clock: decide stimulus at the falling edge, then check the settled outputs
   task automatic cycle();
      pos_t p;
      bit   stalled;
      @(negedge clock);
      cyc++;
      stalled = 1'b0;
      if (stall_rem > 0 && busy && stg_vcnt == stall_v && stg_hcnt == stall_h) begin
         src_valid = 1'b0;
         stall_rem--;
         stalled = 1'b1;
      end else begin
         src_valid = 1'b1;
      end
      #1;
      if (stalled) begin
         checks++;
         if (stg_enable !== 1'b0 || src_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hs cyc %0d: stg_enable=%b src_ready=%b, required 0 0", cyc, stg_enable, src_ready);
         end
      end
      if (src_ready === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL consume_extra cyc %0d: src_ready at (%0d,%0d) with no pixel expected", cyc, stg_vcnt, stg_hcnt);
         end else begin
            p = exp_q.pop_front();
            if (stg_vcnt !== p.v || stg_hcnt !== p.h) begin
               errors++;
               $display("FAIL consume_pos cyc %0d: got (%0d,%0d), required (%0d,%0d)", cyc, stg_vcnt, stg_hcnt, p.v, p.h);
            end
         end
      end
      if (done === 1'b1) begin
         done_seen++;
         done_cyc = cyc;
      end
      if (poke) start = src_ready || done;
   endtask

   task automatic run_frame(input int slen, input bit drop, input bit poke_en,
                            input int exp_lat, input logic [15:0] exp_pool,
                            input logic exp_err, input logic [15:0] exp_stall);
      int s, d0;
      push_frame();
      drop_en   = drop;
      stall_rem = slen;
      d0        = done_seen;
      start     = 1'b1;
      s         = cyc;
      cycle();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || stg_enable !== 1'b1 || stg_vcnt !== 3'd0 || stg_hcnt !== 4'd0
          || pool_count !== 16'd0 || count_err !== 1'b0) begin
         errors++;
         $display("FAIL first_run: busy=%b en=%b pos=(%0d,%0d) pc=%0d err=%b, required 1 1 (0,0) 0 0",
                  busy, stg_enable, stg_vcnt, stg_hcnt, pool_count, count_err);
      end
      poke = poke_en;
      while (done_seen == d0 && cyc < s + 300) cycle();
      poke = 1'b0;
      checks++;
      if (done_seen == d0) begin
         errors++;
         $display("FAIL done_timeout: no done within 300 cycles of start");
      end else begin
         if (done_cyc - s !== exp_lat) begin
            errors++;
            $display("FAIL done_latency: got %0d, required %0d", done_cyc - s, exp_lat);
         end
         checks++;
         if (pool_count !== exp_pool || count_err !== exp_err || stall_count !== exp_stall) begin
            errors++;
            $display("FAIL frame_result: pc=%0d err=%b stalls=%0d, required %0d %b %0d",
                     pool_count, count_err, stall_count, exp_pool, exp_err, exp_stall);
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL consume_missing: %0d pixels never consumed, required 0", exp_q.size());
         exp_q.delete();
      end
      cycle();
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || count_err !== exp_err) begin
         errors++;
         $display("FAIL after_done: busy=%b done=%b err=%b, required 0 0 %b", busy, done, count_err, exp_err);
      end
      drop_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clock);
      rst = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || src_ready !== 1'b0 || stg_enable !== 1'b0 ||
          stg_vcnt !== 3'd0 || stg_hcnt !== 4'd0 || pool_count !== 16'd0 ||
          count_err !== 1'b0 || stall_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b rdy=%b en=%b pos=(%0d,%0d) pc=%0d err=%b st=%0d, required all 0",
                  busy, done, src_ready, stg_enable, stg_vcnt, stg_hcnt, pool_count, count_err, stall_count);
      end
      repeat (3) cycle();
   endtask

   task automatic test_mid_reset();
      int s, d0;
      push_frame();
      d0    = done_seen;
      start = 1'b1;
      s     = cyc;
      cycle();
      start = 1'b0;
      while (!(stg_vcnt == 3'd2 && stg_hcnt == 4'd3) && cyc < s + 100) cycle();
      checks++;
      if (stg_vcnt !== 3'd2 || stg_hcnt !== 4'd3 || busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_reach: pos=(%0d,%0d) busy=%b, required (2,3) 1", stg_vcnt, stg_hcnt, busy);
      end
      rst = 1'b1;
      @(posedge clock);
      #1;
      checks++;
      if (busy !== 1'b0 || stg_enable !== 1'b0 || stg_vcnt !== 3'd0 || stg_hcnt !== 4'd0 || src_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: busy=%b en=%b pos=(%0d,%0d) rdy=%b, required 0 0 (0,0) 0",
                  busy, stg_enable, stg_vcnt, stg_hcnt, src_ready);
      end
      @(negedge clock);
      rst = 1'b0;
      exp_q.delete();
      repeat (100) cycle();
      checks++;
      if (done_seen != d0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_done: done pulses=%0d busy=%b, required 0 0", done_seen - d0, busy);
      end
   endtask

   task automatic test_basic_frame();
      stall_v = 3'd0;
      stall_h = 4'd0;
      run_frame(0, 1'b0, 1'b0, 77, 16'd8, 1'b0, 16'd0);
   endtask

   task automatic test_stall();
      stall_v = 3'd1;
      stall_h = 4'd4;
      run_frame(5, 1'b0, 1'b0, 82, 16'd8, 1'b0, 16'd5);
      checks++;
      if (stall_rem != 0) begin
         errors++;
         $display("FAIL stall_hold: %0d stall cycles unused, required 0", stall_rem);
      end
   endtask

   task automatic test_drop();
      run_frame(0, 1'b1, 1'b0, 77, 16'd7, 1'b1, 16'd0);
      repeat (5) cycle();
      checks++;
      if (count_err !== 1'b1 || pool_count !== 16'd7) begin
         errors++;
         $display("FAIL err_held: err=%b pc=%0d, required 1 7", count_err, pool_count);
      end
   endtask

   task automatic test_start_ignored();
      int d0;
      d0 = done_seen;
      run_frame(0, 1'b0, 1'b1, 77, 16'd8, 1'b0, 16'd0);
      repeat (20) cycle();
      checks++;
      if (done_seen - d0 != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL start_ignored: frames=%0d busy=%b, required 1 0", done_seen - d0, busy);
      end
   endtask

   task automatic test_back_to_back();
      int s, d0;
      push_frame();
      push_frame();
      d0    = done_seen;
      start = 1'b1;
      s     = cyc;
      while (done_seen == d0 && cyc < s + 300) cycle();
      checks++;
      if (done_seen == d0) begin
         errors++;
         $display("FAIL b2b_timeout: no first done");
      end
      cycle();
`ifdef POOL_FRAME_CTRL_CONT_EN
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || stg_enable !== 1'b1 || stg_vcnt !== 3'd0 || stg_hcnt !== 4'd0 || pool_count !== 16'd0) begin
         errors++;
         $display("FAIL b2b_resume: busy=%b en=%b pos=(%0d,%0d) pc=%0d, required 1 1 (0,0) 0",
                  busy, stg_enable, stg_vcnt, stg_hcnt, pool_count);
      end
`else
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle: busy=%b, required 0", busy);
      end
      cycle();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || stg_enable !== 1'b1 || stg_vcnt !== 3'd0 || stg_hcnt !== 4'd0 || pool_count !== 16'd0) begin
         errors++;
         $display("FAIL b2b_resume: busy=%b en=%b pos=(%0d,%0d) pc=%0d, required 1 1 (0,0) 0",
                  busy, stg_enable, stg_vcnt, stg_hcnt, pool_count);
      end
`endif
      d0 = done_seen;
      s  = cyc;
      while (done_seen == d0 && cyc < s + 300) cycle();
      checks++;
      if (done_seen == d0 || pool_count !== 16'd8 || count_err !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_second: done=%0d pc=%0d err=%b left=%0d, required 1 8 0 0",
                  done_seen - d0, pool_count, count_err, exp_q.size());
      end
      exp_q.delete();
      repeat (3) cycle();
   endtask

   initial begin
      test_reset();
      test_mid_reset();
      test_basic_frame();
      test_stall();
      test_drop();
      test_start_ignored();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
